// File: rtl/booth_product_bcd_if.sv
// Handshake and result bus between the Booth multiplier's consumer side and
// the binary-to-BCD converter.
interface booth_product_bcd_if #(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 5
);
  logic                  start;
  logic [IN_WIDTH-1:0]   product;
  logic                  busy;
  logic                  done;
  logic                  sign;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start, product,
    input  busy, done, sign, bcd
  );

  modport slave (
    input  start, product,
    output busy, done, sign, bcd
  );
endinterface

// File: rtl/booth_product_bcd.sv
// Sequential signed-binary to sign+BCD converter (double-dabble, one bit per
// cycle) with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; product magnitude/sign captured on accept
// CONV  | one add-3/shift iteration per cycle, IN_WIDTH cycles total
// DONE  | one-cycle done pulse; bcd/sign were published on entry
module booth_product_bcd #(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_product_bcd_if.slave   cvt_io
);

  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [IN_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]       scr_q, scr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sign_pend_q, sign_pend_d;
  logic                sign_q, sign_d;
  logic [BW-1:0]       bcd_q, bcd_d;

  logic [IN_WIDTH-1:0] magnitude;
  logic [BW-1:0]       scr_adj;
  logic [BW-1:0]       scr_shift;

  // Unsigned view of the negated value: the most negative input maps to
  // 2^(IN_WIDTH-1) without overflow.
  assign magnitude = cvt_io.product[IN_WIDTH-1] ? (~cvt_io.product + 1'b1)
                                                : cvt_io.product;

  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign scr_shift = {scr_adj[BW-2:0], bin_q[IN_WIDTH-1]};

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    scr_d       = scr_q;
    cnt_d       = cnt_q;
    sign_pend_d = sign_pend_q;
    sign_d      = sign_q;
    bcd_d       = bcd_q;

    case (state_q)
      S_IDLE: begin
        if (cvt_io.start) begin
          bin_d       = magnitude;
          scr_d       = '0;
          sign_pend_d = cvt_io.product[IN_WIDTH-1];
          cnt_d       = CW'(IN_WIDTH);
          state_d     = S_CONV;
        end
      end

      S_CONV: begin
        scr_d = scr_shift;
        bin_d = {bin_q[IN_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = scr_shift;
          sign_d  = sign_pend_q;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      scr_q       <= '0;
      cnt_q       <= '0;
      sign_pend_q <= 1'b0;
      sign_q      <= 1'b0;
      bcd_q       <= '0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      scr_q       <= scr_d;
      cnt_q       <= cnt_d;
      sign_pend_q <= sign_pend_d;
      sign_q      <= sign_d;
      bcd_q       <= bcd_d;
    end
  end

  assign cvt_io.busy = (state_q == S_CONV);
  assign cvt_io.done = (state_q == S_DONE);
  assign cvt_io.sign = sign_q;
  assign cvt_io.bcd  = bcd_q;

endmodule

// File: tb/tb_booth_product_bcd.sv
// Self-checking bench for booth_product_bcd: directed table, randomized
// products against an arithmetic decimal model, and handshake corner cases.
module tb_booth_product_bcd;

  logic clk;
  logic rst;

  booth_product_bcd_if #(.IN_WIDTH(16), .DIGITS(5)) bus ();

  booth_product_bcd #(.IN_WIDTH(16), .DIGITS(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .cvt_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  logic [19:0] last_bcd;
  logic        last_sign;

  typedef struct {
    logic [15:0] p;
    logic [19:0] bcd;
    logic        sgn;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] model_bcd(input logic [15:0] p);
    int v, mag;
    logic [19:0] r;
    v   = int'($signed(p));
    mag = (v < 0) ? -v : v;
    r   = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return r;
  endfunction

  function automatic logic model_sign(input logic [15:0] p);
    return ($signed(p) < 0);
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || bus.done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 40), 32'd1);
  endtask

  task automatic run_conv(input logic [15:0] p, output logic [19:0] r_bcd, output logic r_sign);
    int n, nb;
    logic hold_ok;
    wait_idle();
    bus.start   = 1'b1;
    bus.product = p;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.product = 16'($urandom);
    n = 0; nb = 0; hold_ok = 1'b1;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy) nb++;
      if (bus.bcd !== last_bcd || bus.sign !== last_sign) hold_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check("latency", n, 16);
    check("busy_cycles", nb, 16);
    check("result_hold", 32'(hold_ok), 32'd1);
    check("busy_in_done", 32'(bus.busy), 32'd0);
    r_bcd  = bus.bcd;
    r_sign = bus.sign;
    last_bcd  = r_bcd;
    last_sign = r_sign;
    @(negedge clk);
    check("done_width", 32'(bus.done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] r_bcd;
    logic        r_sign;
    logic [15:0] p;
    int          done_cnt, done_t, busy_cnt, busy_low;
    int          prev_done, spacing_ok;

    n_checks = 0;
    n_fail   = 0;
    last_bcd  = '0;
    last_sign = 1'b0;

    vecs[0] = '{16'h0000, 20'h00000, 1'b0};
    vecs[1] = '{16'h3039, 20'h12345, 1'b0};
    vecs[2] = '{16'h7FFF, 20'h32767, 1'b0};
    vecs[3] = '{16'hFFFF, 20'h00001, 1'b1};
    vecs[4] = '{16'h8000, 20'h32768, 1'b1};
    vecs[5] = '{16'hFF9C, 20'h00100, 1'b1};

    rst = 1'b1;
    bus.start   = 1'b0;
    bus.product = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sign", 32'(bus.sign), 32'd0);
    check("rst_bcd",  32'(bus.bcd),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_conv(vecs[i].p, r_bcd, r_sign);
      check("table_bcd", 32'(r_bcd), 32'(vecs[i].bcd));
      check("table_sign", 32'(r_sign), 32'(vecs[i].sgn));
    end

    // Starts during CONV and DONE are ignored
    wait_idle();
    bus.start   = 1'b1;
    bus.product = 16'h0064;
    @(negedge clk);
    bus.start = 1'b0;
    done_cnt = 0; done_t = -1; busy_cnt = 0;
    for (int t = 0; t < 40; t++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_t = t;
        check("ign_bcd", 32'(bus.bcd), 32'h00100);
        check("ign_sign", 32'(bus.sign), 32'd0);
      end
      if (t == 17) check("ign_idle_after_done", 32'(bus.busy), 32'd0);
      if (t == 4) begin
        bus.product = 16'h1234;
        bus.start   = 1'b1;
      end else if (t == 16) begin
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check("ign_done_count", done_cnt, 1);
    check("ign_done_time", done_t, 16);
    check("ign_busy_cycles", busy_cnt, 16);
    last_bcd  = 20'h00100;
    last_sign = 1'b0;

    // Asynchronous reset in the middle of a conversion
    run_conv(16'h3039, r_bcd, r_sign);
    check("pre_rst_bcd", 32'(r_bcd), 32'h12345);
    wait_idle();
    bus.start   = 1'b1;
    bus.product = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_sign", 32'(bus.sign), 32'd0);
    check("arst_bcd",  32'(bus.bcd),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int t = 0; t < 20; t++) begin
      if (bus.done) done_cnt++;
      @(negedge clk);
    end
    check("arst_no_done", done_cnt, 0);
    check("arst_bcd_held", 32'(bus.bcd), 32'd0);
    last_bcd  = '0;
    last_sign = 1'b0;
    run_conv(16'h0007, r_bcd, r_sign);
    check("post_rst_bcd", 32'(r_bcd), 32'h00007);
    check("post_rst_sign", 32'(r_sign), 32'd0);

    // Start held high: back-to-back conversions every 18 cycles
    wait_idle();
    bus.start   = 1'b1;
    bus.product = 16'h0010;
    @(negedge clk);
    done_cnt = 0; busy_low = 0; prev_done = -1; spacing_ok = 1;
    for (int t = 0; t < 60; t++) begin
      if (!bus.busy) busy_low++;
      if (bus.done) begin
        done_cnt++;
        if (prev_done >= 0 && (t - prev_done) != 18) spacing_ok = 0;
        if (prev_done < 0 && t != 16) spacing_ok = 0;
        prev_done = t;
        check("cont_bcd", 32'(bus.bcd), 32'h00016);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("cont_done_count", done_cnt, 3);
    check("cont_spacing", spacing_ok, 1);
    check("cont_busy_low", busy_low, 6);
    wait_idle();
    last_bcd  = 20'h00016;
    last_sign = 1'b0;

    // Randomized products against the decimal model
    for (int i = 0; i < 40; i++) begin
      p = 16'($urandom);
      if (i == 0) p = 16'h8001;
      if (i == 1) p = 16'h0001;
      run_conv(p, r_bcd, r_sign);
      check("rand_bcd", 32'(r_bcd), 32'(model_bcd(p)));
      check("rand_sign", 32'(r_sign), 32'(model_sign(p)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
